// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, counter type and pixel colour type
// for the ship renderer.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int SCREEN_CX = 320;
  localparam int SCREEN_CY = 240;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_END = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_END = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Half-open span test; 17-bit operands keep lo+len from wrapping.
  function automatic logic in_span(input logic [16:0] pos,
                                   input logic [16:0] lo,
                                   input logic [16:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 25 MHz pixel enable, 800x525 raster counters, raw syncs, active flag and
// the one-clock frame_start pulse.
module vga_timing
  import vga_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output cnt_t hc,
  output cnt_t vc,
  output logic hs_raw,
  output logic vs_raw,
  output logic active,
  output logic frame_start
);

  logic h_last;
  logic v_last;
  logic wrap_p0;

  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  // Stage p0: raster position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_en      <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      wrap_p0     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      wrap_p0     <= pix_en & h_last & v_last;
      frame_start <= wrap_p0;
      if (pix_en) begin
        if (h_last) begin
          hc <= '0;
          vc <= v_last ? '0 : vc + cnt_t'(1);
        end else begin
          hc <= hc + cnt_t'(1);
        end
      end
    end
  end

  assign hs_raw = ~((hc >= HS_START) && (hc < HS_END));
  assign vs_raw = ~((vc >= VS_START) && (vc < VS_END));
  assign active = (hc < H_ACT_END) && (vc < V_ACT_END);

endmodule

// File: rtl/vga_ship_renderer.sv
// Paints the ship sprite and central body into a 640x480 VGA stream; the ship
// position is sampled once per frame at the raster wrap.
module vga_ship_renderer
  import vga_pkg::*;
#(
  parameter int          SHIP_SIZE  = 16,
  parameter int          BODY_SIZE  = 8,
  parameter logic [23:0] SHIP_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BODY_COLOR = 24'h2040FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ship_x,
  input  logic [15:0] ship_y,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        frame_start
);

  localparam logic [16:0] SHIP_LEN = 17'(SHIP_SIZE);
  localparam logic [16:0] BODY_LEN = 17'(BODY_SIZE);
  localparam logic [16:0] BODY_X0  = 17'(SCREEN_CX - BODY_SIZE / 2);
  localparam logic [16:0] BODY_Y0  = 17'(SCREEN_CY - BODY_SIZE / 2);

  logic        pix_en;
  cnt_t        hc;
  cnt_t        vc;
  logic        hs_raw;
  logic        vs_raw;
  logic        active;
  logic [15:0] sx;
  logic [15:0] sy;
  logic [16:0] hc_x;
  logic [16:0] vc_x;
  logic        ship_hit;
  logic        body_hit;
  rgb_t        pix_p0;
  rgb_t        rgb_p1;
  logic        hs_p1;
  logic        vs_p1;

  vga_timing u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hc          (hc),
    .vc          (vc),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .active      (active),
    .frame_start (frame_start)
  );

  // Position changes take effect only on the edge that starts a new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sx <= 16'(SCREEN_CX);
      sy <= 16'(SCREEN_CY);
    end else if (pix_en && (hc == H_LAST) && (vc == V_LAST)) begin
      sx <= ship_x;
      sy <= ship_y;
    end
  end

  assign hc_x = {7'd0, hc};
  assign vc_x = {7'd0, vc};

  assign ship_hit = in_span(hc_x, {1'b0, sx}, SHIP_LEN) &&
                    in_span(vc_x, {1'b0, sy}, SHIP_LEN);
  assign body_hit = in_span(hc_x, BODY_X0, BODY_LEN) &&
                    in_span(vc_x, BODY_Y0, BODY_LEN);

  always_comb begin
    pix_p0 = '0;
    if (active) begin
      if (ship_hit) begin
        pix_p0 = rgb_t'(SHIP_COLOR);
      end else if (body_hit) begin
        pix_p0 = rgb_t'(BODY_COLOR);
      end
    end
  end

  // Stage p1: colour and syncs registered together, one pixel behind hc/vc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_p1 <= '0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else if (pix_en) begin
      rgb_p1 <= pix_p0;
      hs_p1  <= hs_raw;
      vs_p1  <= vs_raw;
    end
  end

  assign VGA_R  = rgb_p1.r;
  assign VGA_G  = rgb_p1.g;
  assign VGA_B  = rgb_p1.b;
  assign VGA_HS = hs_p1;
  assign VGA_VS = vs_p1;

endmodule

// File: tb/tb_vga_ship_renderer.sv
// Bench for vga_ship_renderer: pixel-index reference model checked every clock,
// plus literal probes at sprite/body edges, sync widths and reset behaviour.
module tb_vga_ship_renderer;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BODY  = 24'h2040FF;
  localparam int FRAME_PIX = 800 * 525;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ship_x = 16'd100;
  logic [15:0] ship_y = 16'd50;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        frame_start;

  int checks = 0;
  int fails  = 0;

  // Reference model state: pixel index within the frame plus clock phase.
  int          m_ph = 0;
  int          m_p = 0;
  int          m_sx = 320;
  int          m_sy = 240;
  int          m_h = 0;
  int          m_v = 0;
  int          m_out_h = -1;
  int          m_out_v = -1;
  logic [23:0] e_rgb = '0;
  logic        e_hs = 1'b1;
  logic        e_vs = 1'b1;
  logic        e_fs = 1'b0;
  logic        m_wrap = 1'b0;
  int          jump_seq = 0;
  int          seen_seq = 0;
  int          jump_p = 0;
  logic [9:0]  jh = '0;
  logic [9:0]  jv = '0;

  vga_ship_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .ship_x      (ship_x),
    .ship_y      (ship_y),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  function automatic logic [23:0] pixel_of(input int h, input int v,
                                           input int sx, input int sy);
    if (h >= 640 || v >= 480) return 24'h0;
    if (h >= sx && h < sx + 16 && v >= sy && v < sy + 16) return WHITE;
    if (h >= 316 && h < 324 && v >= 236 && v < 244) return BODY;
    return 24'h0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = 0; m_p = 0; m_sx = 320; m_sy = 240;
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; m_wrap = 1'b0;
      m_out_h = -1; m_out_v = -1; seen_seq = jump_seq;
    end else begin
      if (seen_seq != jump_seq) begin
        m_p = jump_p;
        seen_seq = jump_seq;
      end
      e_fs = m_wrap;
      m_wrap = 1'b0;
      if (m_ph == 1) begin
        m_h = m_p % 800;
        m_v = m_p / 800;
        e_rgb = pixel_of(m_h, m_v, m_sx, m_sy);
        e_hs = !(m_h >= 656 && m_h < 752);
        e_vs = !(m_v >= 490 && m_v < 492);
        m_out_h = m_h;
        m_out_v = m_v;
        if (m_p == FRAME_PIX - 1) begin
          m_p = 0;
          m_sx = int'(ship_x);
          m_sy = int'(ship_y);
          m_wrap = 1'b1;
        end else begin
          m_p = m_p + 1;
        end
      end
      m_ph = 1 - m_ph;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== e_rgb || VGA_HS !== e_hs ||
        VGA_VS !== e_vs || frame_start !== e_fs) begin
      fails++;
      $display("FAIL stream t=%0t pix=(%0d,%0d): got rgb=%h hs=%b vs=%b fs=%b, want rgb=%h hs=%b vs=%b fs=%b",
               $time, m_out_h, m_out_v, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS,
               frame_start, e_rgb, e_hs, e_vs, e_fs);
    end
  end

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || VGA_HS !== 1'b1 ||
        VGA_VS !== 1'b1 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b fs=%b, want rgb=000000 hs=1 vs=1 fs=0",
               name, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, frame_start);
    end
  endtask

  // Waits until the outputs show pixel (h,v), then compares against a literal.
  task automatic probe(input int h, input int v, input logic [23:0] want);
    int n;
    n = 0;
    while (!(m_out_h == h && m_out_v == v) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      fails++;
      $display("FAIL probe(%0d,%0d): pixel never reached, want %h", h, v, want);
    end else if ({VGA_R, VGA_G, VGA_B} !== want) begin
      fails++;
      $display("FAIL probe(%0d,%0d): got %h, want %h", h, v, {VGA_R, VGA_G, VGA_B}, want);
    end
  endtask

  // Moves the raster to (h,v) in both DUT and model between clock edges.
  task jump(input int h, input int v);
    @(negedge clk);
    jh = 10'(h);
    jv = 10'(v);
    force dut.u_timing.hc = jh;
    force dut.u_timing.vc = jv;
    jump_p = v * 800 + h;
    jump_seq++;
    #2;
    release dut.u_timing.hc;
    release dut.u_timing.vc;
  endtask

  task automatic measure_hs(input string tag);
    int n;
    int w;
    n = 0;
    while (VGA_HS === 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    expect_int({tag, "_hs_first_fall"}, n, 1314);
    w = 0;
    while (VGA_HS === 1'b0 && w < 3000) begin @(posedge clk); #1; w++; end
    expect_int({tag, "_hs_low"}, w, 192);
    while (VGA_HS === 1'b1 && w < 3000) begin @(posedge clk); #1; w++; end
    expect_int({tag, "_hs_period"}, w, 1600);
  endtask

  task automatic wrap_frame();
    int n;
    jump(790, 524);
    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    expect_int("frame_start_delay_ok", (n == 20 || n == 21) ? 1 : 0, 1);
    @(negedge clk);
    expect_int("frame_start_one_clk", int'(frame_start), 0);
  endtask

  initial begin
    int n;
    #5 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ship_x = 16'(i * 7 + 3);
      check_idle("reset_hold");
    end
    ship_x = 16'd100;
    ship_y = 16'd50;
    @(negedge clk);
    reset = 1'b1;
    measure_hs("por");

    // Vertical sync width
    jump(700, 489);
    n = 0;
    while (VGA_VS !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    n = 0;
    while (VGA_VS === 1'b0 && n < 5000) begin @(negedge clk); n++; end
    expect_int("vs_low_clks", n, 3200);

    // Sprite at (100,50) and the central body
    wrap_frame();
    jump(90, 50);
    probe(99, 50, 24'h0); probe(100, 50, WHITE); probe(115, 50, WHITE); probe(116, 50, 24'h0);
    jump(90, 49);
    probe(100, 49, 24'h0);
    jump(90, 65);
    probe(100, 65, WHITE); probe(115, 65, WHITE);
    jump(90, 66);
    probe(100, 66, 24'h0);
    jump(310, 236);
    probe(315, 236, 24'h0); probe(316, 236, BODY); probe(323, 236, BODY); probe(324, 236, 24'h0);
    jump(310, 243);
    probe(316, 243, BODY);
    jump(310, 244);
    probe(316, 244, 24'h0);

    // Mid-frame position change waits for the next frame
    jump(90, 60);
    probe(100, 60, WHITE);
    ship_x = 16'd200;
    jump(90, 63);
    probe(100, 63, WHITE); probe(200, 63, 24'h0);
    wrap_frame();
    jump(90, 50);
    probe(100, 50, 24'h0); probe(200, 50, WHITE);

    // Right-edge clipping
    ship_x = 16'd632;
    ship_y = 16'd0;
    wrap_frame();
    probe(631, 0, 24'h0); probe(632, 0, WHITE); probe(639, 0, WHITE); probe(640, 0, 24'h0);

    // Far-right position must not wrap into view
    ship_x = 16'd65530;
    wrap_frame();
    probe(0, 0, 24'h0); probe(5, 0, 24'h0); probe(9, 1, 24'h0);

    // Ship over the body
    ship_x = 16'd316;
    ship_y = 16'd236;
    wrap_frame();
    jump(310, 236);
    probe(316, 236, WHITE); probe(331, 236, WHITE); probe(332, 236, 24'h0);
    jump(310, 243);
    probe(323, 243, WHITE);

    // Reset asserted mid-frame while the ship is being drawn
    ship_x = 16'd392;
    ship_y = 16'd192;
    wrap_frame();
    jump(380, 200);
    probe(399, 200, WHITE);
    @(posedge clk);
    #5 reset = 1'b0;
    #1 check_idle("async_reset_assert");
    @(negedge clk);
    @(negedge clk);
    check_idle("reset_held");
    reset = 1'b1;
    measure_hs("rearm");
    jump(310, 240);
    probe(316, 240, BODY); probe(319, 240, BODY); probe(320, 240, WHITE);
    probe(335, 240, WHITE); probe(336, 240, 24'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_ship_renderer.md
# vga_ship_renderer

Downstream display stage of the space-shooter datapath. It consumes the physics block's `ship_x`/`ship_y` position, generates 640x480@60 Hz VGA timing from the 50 MHz system clock, and paints the ship sprite and the central gravitational body into the pixel stream. Ship position is sampled once per frame, so a frame never shows a ship torn between two positions.

## Interface
Parameters:
- `SHIP_SIZE`, default 16: ship square edge, in pixels.
- `BODY_SIZE`, default 8: central-body square edge, in pixels. The square is centred on (320,240).
- `SHIP_COLOR`, default 24'hFFFFFF: ship RGB value.
- `BODY_COLOR`, default 24'h2040FF: central-body RGB value.

Ports:
- `clk`, in, 1: 50 MHz system clock.
- `reset`, in, 1: reset, asynchronous and active-low.
- `ship_x`, in, 16: ship top-left x, in pixels, unsigned.
- `ship_y`, in, 16: ship top-left y, in pixels, unsigned.
- `VGA_R`, out, 8: red.
- `VGA_G`, out, 8: green.
- `VGA_B`, out, 8: blue.
- `VGA_HS`, out, 1: horizontal sync, active-low.
- `VGA_VS`, out, 1: vertical sync, active-low.
- `frame_start`, out, 1: one-`clk` pulse when the counters wrap to (0,0).

## Operation
- **Pixel enable.** `pix_en` toggles every `clk` edge and resets to 0. This gives a 25 MHz pixel rate.
- **Counters.** `hc` (0..799) and `vc` (0..524) advance only on edges where `pix_en`=1.
  - `hc` wraps 799→0 and increments `vc` at the same edge.
  - `vc` wraps 524→0 when `hc` wraps.
- **Horizontal regions** (`hc`): active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- **Vertical regions** (`vc`): active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- **Position latch.** On the pixel edge where (`hc`,`vc`)=(799,524), `ship_x`/`ship_y` are copied into `sx`/`sy`. Input changes at any other time are ignored until that edge.
- **Hit test.**
  - ship_hit = `hc`∈[`sx`, `sx`+SHIP_SIZE) and `vc`∈[`sy`, `sy`+SHIP_SIZE).
  - body_hit = `hc`∈[316,324) and `vc`∈[236,244) for the default `BODY_SIZE`.
  - All compares use 17-bit zero-extended sums, so `sx` near 65535 cannot wrap into view.
- **Colour priority.** Blanking forces 0. Otherwise ship beats body, and body beats background (0).
- **Clipping.** A ship partly beyond column 639 or row 479 is clipped naturally. If `sx`≥640 or `sy`≥480, no ship pixels appear.
- **Reset values.** `pix_en`=0, `hc`=0, `vc`=0, `sx`=320, `sy`=240, RGB=0, `VGA_HS`=1, `VGA_VS`=1, `frame_start`=0.
- **Reset mid-frame.** Assertion immediately forces all reset values. After release, counting restarts from (0,0) with no partial sync pulse.

## Timing
- **Output registers.** RGB, `VGA_HS` and `VGA_VS` are registered together on `pix_en` edges.
  - They reflect the (`hc`,`vc`) value present before that edge, giving a latency of 1 pixel (2 `clk`).
  - All three outputs stay mutually aligned.
- **First count.** After reset release, the first counter advance happens on the 2nd `clk` edge.
- **HS pulse.** 96 pixels = 192 `clk` low, once every 800 pixels. **VS pulse.** 2 lines = 1600 pixels low, once every 525 lines.
- **`frame_start`.** High for exactly one `clk`, on the edge after the `pix_en` edge that sets `hc`=`vc`=0.
- **Latch timing.** The `sx`/`sy` update occurs on the same edge as the counter wrap, so the new position applies to the first pixel of the new frame.

## Structure
- **Package `vga_pkg`.**
  - Constants: H_ACTIVE/H_FP/H_SYNC/H_BP, V_ACTIVE/V_FP/V_SYNC/V_BP, H_TOTAL=800, V_TOTAL=525, SCREEN_CX=320, SCREEN_CY=240.
  - Typedef: `rgb_t` (24-bit packed r/g/b).
- **Sub-module `vga_timing`.** Contains `pix_en`, `hc`/`vc`, raw sync, the `active` flag and `frame_start`.
- **`vga_ship_renderer` itself.** Contains the latch, hit test, colour mux and output registers.

## Test plan
- **Reset.** Hold `reset`=0 for 5 cycles, then release → during reset all outputs hold their reset values. The first `VGA_HS` falling edge comes 2×(656+1) `clk` after release.
- **Sync periods.**
  - `VGA_HS` low for 192 `clk` in every 1600.
  - `VGA_VS` low for 3200 `clk` in every 840000.
  - `frame_start` pulses every 840000 `clk`.
- **Sprite placement.** `ship_x`=100, `ship_y`=50 held over a frame → in the next frame RGB=FFFFFF exactly for `hc` 100..115, `vc` 50..65; BODY_COLOR at 316..323/236..243; 0 elsewhere.
- **Latch.** Change `ship_x` 100→200 at `vc`=300 → the rest of the current frame still shows the ship at 100; the next frame shows it at 200.
- **Clipping and wrap.**
  - `ship_x`=632 → ship drawn at `hc` 632..639 only, nothing during blanking.
  - `ship_x`=65530 → no ship pixels at all.
- **Overlap and mid-frame reset.**
  - Ship at (316,236) → ship colour wins over the body.
  - Assert `reset` at `hc`=400, `vc`=200 → RGB=0 and syncs=1 immediately, and (0,0) restarts after release.
